// File: rtl/iterative_shifter_if.sv
// Request/response bundle for iterative_shifter: operand request in, shifted result out,
// plus status (busy, op_count) and an FSM state debug tap.
interface iterative_shifter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  localparam int SH_W = $clog2(XLEN);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  operand;
  logic [SH_W-1:0]  shamt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, op, operand, shamt, flush, out_ready,
    input  in_ready, out_valid, result, illegal, busy, op_count, dbg_state
  );

  modport slave (
    input  in_valid, op, operand, shamt, flush, out_ready,
    output in_ready, out_valid, result, illegal, busy, op_count, dbg_state
  );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bit positions per BUSY cycle,
// returns the result through a valid/ready handshake and counts completed operations.
module iterative_shifter #(
  parameter int XLEN  = 32,
  parameter int STEP  = 4,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  iterative_shifter_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W:0] STEP_K = (SH_W+1)'(STEP);
  localparam logic [SH_W:0] XLEN_K = (SH_W+1)'(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  work;
  logic [XLEN-1:0]  work_nxt;
  logic [SH_W-1:0]  remaining;
  logic [SH_W-1:0]  rem_nxt;
  logic [SH_W:0]    k;
  logic [SH_W:0]    rem_diff;
  logic             illegal_q;
  logic             op_illegal;
  logic [CNT_W-1:0] op_count_q;

  assign op_illegal = (bus.op > OP_ROR);

  // One step of the datapath: k = min(remaining, STEP). SRA keeps the work MSB,
  // which is always the latched operand MSB, so it fills correctly across steps.
  always_comb begin
    k        = ({1'b0, remaining} < STEP_K) ? {1'b0, remaining} : STEP_K;
    rem_diff = {1'b0, remaining} - k;
    rem_nxt  = rem_diff[SH_W-1:0];
    work_nxt = work;
    case (op_q)
      OP_SLL:  work_nxt = work << k;
      OP_SRL:  work_nxt = work >> k;
      OP_SRA:  work_nxt = $signed(work) >>> k;
      OP_ROL:  work_nxt = (work << k) | (work >> (XLEN_K - k));
      OP_ROR:  work_nxt = (work >> k) | (work << (XLEN_K - k));
      default: work_nxt = work;
    endcase
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid only in DONE, holding result until out_ready.
  // Requests with no work (shamt 0 or illegal op) still spend one BUSY cycle with k=0,
  // so the result latency is uniformly max(1, ceil(shamt/STEP)).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_SLL;
      work       <= '0;
      remaining  <= '0;
      illegal_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q      <= bus.op;
            work      <= bus.operand;
            remaining <= op_illegal ? '0 : bus.shamt;
            illegal_q <= op_illegal;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            work      <= work_nxt;
            remaining <= rem_nxt;
            if (rem_nxt == '0) state <= DONE;
          end
        end
        DONE: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (bus.out_ready) begin
            state <= IDLE;
            if (op_count_q != '1) op_count_q <= op_count_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = work;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (state != IDLE);
  assign bus.op_count  = op_count_q;
  assign bus.dbg_state = state;
endmodule
